wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-side consumer of the W pipeline register in the Y86-64 pipelined core. It commits W-stage results into the 15-entry architectural register file and serves the two decode-stage read ports. It also tracks architectural processor status (run/halt/error) and drives the W-stage stall back to the W register. It sits between the W pipeline register outputs and the decode stage.

## Interface
- No parameters. Widths come from shared defines: `NIBBLE` = 4 bits, `D_WORD` = 64 bits.
- clk_i  in  1  core clock; all state updates on its rising edge
- rstn_i  in  1  reset, asynchronous and active-low; clears all state immediately
- W_stat_i  in  4  status of the instruction in W
- W_icode_i  in  4  icode of the instruction in W
- W_valE_i  in  64  ALU result
- W_valM_i  in  64  memory read result
- W_dstE_i  in  4  destination for valE (RNONE = 4'hF means none)
- W_dstM_i  in  4  destination for valM (RNONE = none)
- d_srcA_i  in  4  decode read address A
- d_srcB_i  in  4  decode read address B
- d_rvalA_o  out  64  combinational read data A; 0 when d_srcA_i = RNONE
- d_rvalB_o  out  64  combinational read data B; 0 when d_srcB_i = RNONE
- W_stall_o  out  1  drives W_stall_i of the W pipeline register
- cpu_stat_o  out  4  architectural status
- halted_o  out  1  high when the state is not RUN
- retired_o  out  32  count of committed instructions

## Operation
- Status encodings: SBUB = 0, SAOK = 1, SHLT = 2, SADR = 3, SINS = 4.
- State machine, states RUN, HALT and ERR:
  - RUN → HALT when W_stat_i = SHLT.
  - RUN → ERR when W_stat_i is SADR or SINS.
  - HALT and ERR are sticky until reset.
- Commit condition: state = RUN and W_stat_i = SAOK. SBUB and exception statuses never write.
- On commit:
  - If W_dstE_i ≠ RNONE, write W_valE_i to regs[W_dstE_i].
  - If W_dstM_i ≠ RNONE, write W_valM_i to regs[W_dstM_i].
  - If W_dstE_i = W_dstM_i ≠ RNONE, valM wins (popq %rsp semantics).
- retired_o increments by 1 per commit cycle and wraps from 32'hFFFF_FFFF to 0. W_icode_i does not gate it.
- cpu_stat_o:
  - SAOK while in RUN, including when W holds SBUB.
  - In HALT or ERR, holds the latched W_stat_i value that caused the transition.
- W_stall_o (combinational) = 1 when W_stat_i ∈ {SHLT, SADR, SINS} or state ≠ RUN.
- W_icode_i is carried for debug/trace only and does not affect any output.

## Timing
- Reset (asynchronous): regs all 0, state RUN, cpu_stat_o = SAOK, halted_o = 0, retired_o = 0.
- W_stall_o follows W_stat_i combinationally, even while rstn_i is low.
- Reset assertion mid-operation clears state immediately. Deassertion is synchronised externally; the first edge after deassertion may commit.
- Write latency: a commit at edge N makes data visible on the read ports after edge N. The same-cycle behaviour is set by the Configuration macro.
- State transition takes effect at the edge sampling the exception:
  - halted_o and cpu_stat_o change after that edge.
  - No register write or counter increment occurs on that edge or any later one.

## Configuration
- WB_BYPASS_EN defined: a read whose address matches an active commit target returns the pending write data in the same cycle. valM has priority over valE; the RNONE rule still applies.
- WB_BYPASS_EN undefined: reads return array contents only. The new value is visible from the cycle after the write edge; decode relies on pipeline forwarding.

## Structure
- Shared define file holds:
  - `NIBBLE`, `D_WORD`
  - RNONE
  - status codes SBUB, SAOK, SHLT, SADR, SINS
  - new WB state encodings WB_RUN = 2'd0, WB_HALT = 2'd1, WB_ERR = 2'd2
- Sub-module y86_regfile:
  - 15 × 64 array, two write ports with valM priority, two combinational read ports.
  - Contains the WB_BYPASS_EN logic.
  - Reset asynchronous and active-low, same port naming.
- Top-level wb_regfile holds the state machine, commit gating, retire counter and stall logic.

## Test plan
- Commit E only: W_stat_i = SAOK, W_dstE_i = 0, W_valE_i = 64'h5, W_dstM_i = RNONE, one edge → d_srcA_i = 0 reads 64'h5; retired_o = 1.
- Same destination: W_dstE_i = W_dstM_i = 4, valE = 64'h10, valM = 64'hAA → regs[4] = 64'hAA.
- Same-cycle read of a committing address: d_srcB_i = 2 while committing W_dstE_i = 2, valE = 64'h7 → d_rvalB_o = 64'h7 in that cycle when WB_BYPASS_EN is defined, old value when undefined.
- Halt: W_stat_i = SHLT with W_dstE_i = 1, valE = 64'h9 →
  - W_stall_o = 1 in the same cycle.
  - After the edge: halted_o = 1, cpu_stat_o = SHLT.
  - regs[1] unchanged; retired_o unchanged.
  - A following SAOK commit is ignored.
- Error: W_stat_i = SINS → cpu_stat_o = SINS, halted_o = 1, sticky across 5 SAOK cycles. Asserting rstn_i low mid-cycle → immediately cpu_stat_o = SAOK, halted_o = 0, retired_o = 0, regs = 0.
- Bubble and wrap: W_stat_i = SBUB with W_dstE_i = 3 → no write, no count. Preload retired_o to 32'hFFFF_FFFF with a commit → 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths, register/status encodings and writeback state codes.
`default_nettype none

`ifndef NIBBLE
`define NIBBLE 4
`endif
`ifndef D_WORD
`define D_WORD 64
`endif

package wb_regfile_pkg;

  localparam int NIBBLE_W = `NIBBLE;
  localparam int D_WORD_W = `D_WORD;

  localparam logic [`NIBBLE-1:0] RNONE = 4'hF;

  localparam logic [`NIBBLE-1:0] SBUB = 4'd0;
  localparam logic [`NIBBLE-1:0] SAOK = 4'd1;
  localparam logic [`NIBBLE-1:0] SHLT = 4'd2;
  localparam logic [`NIBBLE-1:0] SADR = 4'd3;
  localparam logic [`NIBBLE-1:0] SINS = 4'd4;

  typedef enum logic [1:0] {
    WB_RUN  = 2'd0,
    WB_HALT = 2'd1,
    WB_ERR  = 2'd2
  } wb_state_t;

  function automatic logic is_stop_stat(input logic [`NIBBLE-1:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/y86_regfile.sv
// y86_regfile: 15 x 64 register array, two write ports (valM wins), two read ports.
// Same-cycle write-to-read bypass is built when WB_BYPASS_EN is defined.
`default_nettype none

module y86_regfile
  import wb_regfile_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 we_e_i,
  input  logic [`NIBBLE-1:0]   waddr_e_i,
  input  logic [`D_WORD-1:0]   wdata_e_i,
  input  logic                 we_m_i,
  input  logic [`NIBBLE-1:0]   waddr_m_i,
  input  logic [`D_WORD-1:0]   wdata_m_i,
  input  logic [`NIBBLE-1:0]   raddr_a_i,
  input  logic [`NIBBLE-1:0]   raddr_b_i,
  output logic [`D_WORD-1:0]   rdata_a_o,
  output logic [`D_WORD-1:0]   rdata_b_o
);

  logic [`D_WORD-1:0] r_regs [0:14];
  logic [`D_WORD-1:0] w_arr_a;
  logic [`D_WORD-1:0] w_arr_b;

  // Write enables are only raised for real register numbers, so index 15 never lands here.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (we_e_i) r_regs[waddr_e_i] <= wdata_e_i;
      if (we_m_i) r_regs[waddr_m_i] <= wdata_m_i;
    end
  end

  always_comb begin
    w_arr_a = '0;
    w_arr_b = '0;
    if (raddr_a_i != RNONE) w_arr_a = r_regs[raddr_a_i];
    if (raddr_b_i != RNONE) w_arr_b = r_regs[raddr_b_i];
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rdata_a_o = w_arr_a;
    rdata_b_o = w_arr_b;
    if (raddr_a_i != RNONE) begin
      if (we_m_i && (waddr_m_i == raddr_a_i))      rdata_a_o = wdata_m_i;
      else if (we_e_i && (waddr_e_i == raddr_a_i)) rdata_a_o = wdata_e_i;
    end
    if (raddr_b_i != RNONE) begin
      if (we_m_i && (waddr_m_i == raddr_b_i))      rdata_b_o = wdata_m_i;
      else if (we_e_i && (waddr_e_i == raddr_b_i)) rdata_b_o = wdata_e_i;
    end
  end
`else
  assign rdata_a_o = w_arr_a;
  assign rdata_b_o = w_arr_b;
`endif

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// wb_regfile: Y86-64 writeback stage - commit gating, run/halt/error status, retire count,
// W stall. Optional macro WB_BYPASS_EN enables same-cycle read bypass in y86_regfile.
`default_nettype none

module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [`NIBBLE-1:0]   W_stat_i,
  input  logic [`NIBBLE-1:0]   W_icode_i,
  input  logic [`D_WORD-1:0]   W_valE_i,
  input  logic [`D_WORD-1:0]   W_valM_i,
  input  logic [`NIBBLE-1:0]   W_dstE_i,
  input  logic [`NIBBLE-1:0]   W_dstM_i,
  input  logic [`NIBBLE-1:0]   d_srcA_i,
  input  logic [`NIBBLE-1:0]   d_srcB_i,
  output logic [`D_WORD-1:0]   d_rvalA_o,
  output logic [`D_WORD-1:0]   d_rvalB_o,
  output logic                 W_stall_o,
  output logic [`NIBBLE-1:0]   cpu_stat_o,
  output logic                 halted_o,
  output logic [31:0]          retired_o
);

  wb_state_t          r_state;
  wb_state_t          w_state_nxt;
  logic [`NIBBLE-1:0] r_cpu_stat;
  logic [31:0]        r_retired;
  logic               w_commit;
  logic               w_stall;
  logic               w_we_e;
  logic               w_we_m;
  logic               w_unused_icode;

  // icode travels with W only for trace visibility.
  assign w_unused_icode = ^W_icode_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= WB_RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_stall     = 1'b1;
    case (r_state)
      WB_RUN: begin
        w_stall  = is_stop_stat(W_stat_i);
        w_commit = (W_stat_i == SAOK);
        if (W_stat_i == SHLT)                           w_state_nxt = WB_HALT;
        else if ((W_stat_i == SADR) || (W_stat_i == SINS)) w_state_nxt = WB_ERR;
      end
      default: begin
        w_stall = 1'b1;
      end
    endcase
  end

  // The status that caused leaving RUN is captured once; HALT/ERR never exit without reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cpu_stat <= SAOK;
      r_retired  <= '0;
    end else begin
      if ((r_state == WB_RUN) && (w_state_nxt != WB_RUN)) r_cpu_stat <= W_stat_i;
      if (w_commit) r_retired <= r_retired + 32'd1;
    end
  end

  assign w_we_e = w_commit && (W_dstE_i != RNONE);
  assign w_we_m = w_commit && (W_dstM_i != RNONE);

  y86_regfile u_regfile (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .we_e_i    (w_we_e),
    .waddr_e_i (W_dstE_i),
    .wdata_e_i (W_valE_i),
    .we_m_i    (w_we_m),
    .waddr_m_i (W_dstM_i),
    .wdata_m_i (W_valM_i),
    .raddr_a_i (d_srcA_i),
    .raddr_b_i (d_srcB_i),
    .rdata_a_o (d_rvalA_o),
    .rdata_b_o (d_rvalB_o)
  );

  assign W_stall_o  = w_stall;
  assign cpu_stat_o = r_cpu_stat;
  assign halted_o   = (r_state != WB_RUN);
  assign retired_o  = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scenario tasks with a queue of expected values popped at each sample point.
`default_nettype none

module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic [3:0]  W_stat_i = SBUB;
  logic [3:0]  W_icode_i = 4'h0;
  logic [63:0] W_valE_i = '0;
  logic [63:0] W_valM_i = '0;
  logic [3:0]  W_dstE_i = RNONE;
  logic [3:0]  W_dstM_i = RNONE;
  logic [3:0]  d_srcA_i = RNONE;
  logic [3:0]  d_srcB_i = RNONE;
  logic [63:0] d_rvalA_o;
  logic [63:0] d_rvalB_o;
  logic        W_stall_o;
  logic [3:0]  cpu_stat_o;
  logic        halted_o;
  logic [31:0] retired_o;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_v;

  always #5 clk_i = ~clk_i;

  wb_regfile dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .W_stat_i   (W_stat_i),
    .W_icode_i  (W_icode_i),
    .W_valE_i   (W_valE_i),
    .W_valM_i   (W_valM_i),
    .W_dstE_i   (W_dstE_i),
    .W_dstM_i   (W_dstM_i),
    .d_srcA_i   (d_srcA_i),
    .d_srcB_i   (d_srcB_i),
    .d_rvalA_o  (d_rvalA_o),
    .d_rvalB_o  (d_rvalB_o),
    .W_stall_o  (W_stall_o),
    .cpu_stat_o (cpu_stat_o),
    .halted_o   (halted_o),
    .retired_o  (retired_o)
  );

  task automatic drive(input logic [3:0] stat, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    W_stat_i  = stat;
    W_dstE_i  = de;
    W_valE_i  = ve;
    W_dstM_i  = dm;
    W_valM_i  = vm;
    W_icode_i = 4'($urandom_range(0, 15));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2 rstn_i = 1'b0;
    drive(SHLT, RNONE, '0, RNONE, '0);
    d_srcA_i = 4'd0;
    d_srcB_i = RNONE;
    @(negedge clk_i);
    sb.push_back(64'(SAOK)); sb.push_back(64'd0); sb.push_back(64'd0);
    sb.push_back(64'd0); sb.push_back(64'd1);
    exp_v = sb.pop_front(); checks++;
    if (64'(cpu_stat_o) !== exp_v) begin failures++; $display("FAIL reset_stat got=%h exp=%h", cpu_stat_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(halted_o) !== exp_v) begin failures++; $display("FAIL reset_halted got=%h exp=%h", halted_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL reset_retired got=%h exp=%h", retired_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL reset_reg0 got=%h exp=%h", d_rvalA_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(W_stall_o) !== exp_v) begin failures++; $display("FAIL reset_stall got=%h exp=%h", W_stall_o, exp_v); end
    drive(SBUB, RNONE, '0, RNONE, '0);
    rstn_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_commit_e();
    drive(SAOK, 4'd0, 64'h5, RNONE, 64'hDEAD);
    d_srcA_i = 4'd0;
    d_srcB_i = RNONE;
    sb.push_back(64'h5); sb.push_back(64'd0); sb.push_back(64'd1);
    step();
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL commit_e_reg0 got=%h exp=%h", d_rvalA_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d_rvalB_o !== exp_v) begin failures++; $display("FAIL commit_e_rnone got=%h exp=%h", d_rvalB_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL commit_e_retired got=%h exp=%h", retired_o, exp_v); end
    @(negedge clk_i);
  endtask

  task automatic test_same_dst();
    drive(SAOK, 4'd4, 64'h10, 4'd4, 64'hAA);
    sb.push_back(64'hAA);
    step();
    d_srcA_i = 4'd4;
    #1;
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL same_dst_reg4 got=%h exp=%h", d_rvalA_o, exp_v); end
    @(negedge clk_i);
    drive(SAOK, RNONE, 64'h77, 4'd6, 64'h1234);
    d_srcB_i = 4'd6;
    sb.push_back(64'h1234); sb.push_back(64'd3);
    step();
    exp_v = sb.pop_front(); checks++;
    if (d_rvalB_o !== exp_v) begin failures++; $display("FAIL dstm_only_reg6 got=%h exp=%h", d_rvalB_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL dstm_only_retired got=%h exp=%h", retired_o, exp_v); end
    @(negedge clk_i);
  endtask

  task automatic test_bypass();
    drive(SAOK, 4'd2, 64'h7, RNONE, '0);
    d_srcB_i = 4'd2;
`ifdef WB_BYPASS_EN
    sb.push_back(64'h7);
`else
    sb.push_back(64'h0);
`endif
    sb.push_back(64'h7);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (d_rvalB_o !== exp_v) begin failures++; $display("FAIL bypass_same_cycle got=%h exp=%h", d_rvalB_o, exp_v); end
    step();
    exp_v = sb.pop_front(); checks++;
    if (d_rvalB_o !== exp_v) begin failures++; $display("FAIL bypass_after_edge got=%h exp=%h", d_rvalB_o, exp_v); end
    @(negedge clk_i);
  endtask

  task automatic test_bubble_wrap();
    drive(SBUB, 4'd3, 64'h33, RNONE, '0);
    d_srcA_i = 4'd3;
    sb.push_back(64'd0); sb.push_back(64'd4);
    step();
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL bubble_reg3 got=%h exp=%h", d_rvalA_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL bubble_retired got=%h exp=%h", retired_o, exp_v); end
    @(negedge clk_i);
    force dut.r_retired = 32'hFFFF_FFFF;
    #1 release dut.r_retired;
    drive(SAOK, 4'd5, 64'h1, RNONE, '0);
    sb.push_back(64'd0);
    step();
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL wrap_retired got=%h exp=%h", retired_o, exp_v); end
    @(negedge clk_i);
  endtask

  task automatic test_halt();
    drive(SHLT, 4'd1, 64'h9, RNONE, '0);
    d_srcA_i = 4'd1;
    sb.push_back(64'd1); sb.push_back(64'd0);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (64'(W_stall_o) !== exp_v) begin failures++; $display("FAIL halt_stall got=%h exp=%h", W_stall_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(halted_o) !== exp_v) begin failures++; $display("FAIL halt_pre_edge got=%h exp=%h", halted_o, exp_v); end
    sb.push_back(64'd1); sb.push_back(64'(SHLT)); sb.push_back(64'd0); sb.push_back(64'd0);
    step();
    exp_v = sb.pop_front(); checks++;
    if (64'(halted_o) !== exp_v) begin failures++; $display("FAIL halt_halted got=%h exp=%h", halted_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(cpu_stat_o) !== exp_v) begin failures++; $display("FAIL halt_stat got=%h exp=%h", cpu_stat_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL halt_reg1 got=%h exp=%h", d_rvalA_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL halt_retired got=%h exp=%h", retired_o, exp_v); end
    @(negedge clk_i);
    drive(SAOK, 4'd1, 64'h99, RNONE, '0);
    sb.push_back(64'd1); sb.push_back(64'd0); sb.push_back(64'd0); sb.push_back(64'(SHLT));
    #1;
    exp_v = sb.pop_front(); checks++;
    if (64'(W_stall_o) !== exp_v) begin failures++; $display("FAIL halt_sticky_stall got=%h exp=%h", W_stall_o, exp_v); end
    step();
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL halt_ignored_reg1 got=%h exp=%h", d_rvalA_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL halt_ignored_retired got=%h exp=%h", retired_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(cpu_stat_o) !== exp_v) begin failures++; $display("FAIL halt_sticky_stat got=%h exp=%h", cpu_stat_o, exp_v); end
    #2 rstn_i = 1'b0;
    #1;
    sb.push_back(64'(SAOK)); sb.push_back(64'd0);
    exp_v = sb.pop_front(); checks++;
    if (64'(cpu_stat_o) !== exp_v) begin failures++; $display("FAIL halt_reset_stat got=%h exp=%h", cpu_stat_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(halted_o) !== exp_v) begin failures++; $display("FAIL halt_reset_halted got=%h exp=%h", halted_o, exp_v); end
    drive(SBUB, RNONE, '0, RNONE, '0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_error();
    drive(SAOK, 4'd4, 64'hAB, RNONE, '0);
    d_srcA_i = 4'd4;
    d_srcB_i = 4'd7;
    sb.push_back(64'hAB);
    step();
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL err_pre_reg4 got=%h exp=%h", d_rvalA_o, exp_v); end
    @(negedge clk_i);
    drive(SINS, 4'd7, 64'h55, RNONE, '0);
    step();
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      drive(SAOK, 4'd7, 64'h100 + 64'(i), RNONE, '0);
      step();
      @(negedge clk_i);
    end
    sb.push_back(64'(SINS)); sb.push_back(64'd1); sb.push_back(64'd0); sb.push_back(64'd1);
    exp_v = sb.pop_front(); checks++;
    if (64'(cpu_stat_o) !== exp_v) begin failures++; $display("FAIL err_stat got=%h exp=%h", cpu_stat_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(halted_o) !== exp_v) begin failures++; $display("FAIL err_halted got=%h exp=%h", halted_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d_rvalB_o !== exp_v) begin failures++; $display("FAIL err_reg7 got=%h exp=%h", d_rvalB_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL err_retired got=%h exp=%h", retired_o, exp_v); end
    #2 rstn_i = 1'b0;
    #1;
    sb.push_back(64'(SAOK)); sb.push_back(64'd0); sb.push_back(64'd0); sb.push_back(64'd0);
    exp_v = sb.pop_front(); checks++;
    if (64'(cpu_stat_o) !== exp_v) begin failures++; $display("FAIL err_reset_stat got=%h exp=%h", cpu_stat_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(halted_o) !== exp_v) begin failures++; $display("FAIL err_reset_halted got=%h exp=%h", halted_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (64'(retired_o) !== exp_v) begin failures++; $display("FAIL err_reset_retired got=%h exp=%h", retired_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL err_reset_reg4 got=%h exp=%h", d_rvalA_o, exp_v); end
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    drive(SADR, 4'd8, 64'h3, RNONE, '0);
    d_srcA_i = 4'd8;
    sb.push_back(64'(SADR)); sb.push_back(64'd0);
    step();
    exp_v = sb.pop_front(); checks++;
    if (64'(cpu_stat_o) !== exp_v) begin failures++; $display("FAIL adr_stat got=%h exp=%h", cpu_stat_o, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (d_rvalA_o !== exp_v) begin failures++; $display("FAIL adr_reg8 got=%h exp=%h", d_rvalA_o, exp_v); end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_commit_e();
    test_same_dst();
    test_bypass();
    test_bubble_wrap();
    test_halt();
    test_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
